// File: rtl/circ_mtx_vec_mul_seq.sv
// circ_mtx_vec_mul_seq
//
// Sequential circulant matrix-vector multiplier over GF(2^31-1).
// The matrix C is defined by its first row. Row r is that row rotated right by r.
// mode_i = 0 computes y = C * x, and mode_i = 1 computes y = C^T * x.
// The block processes LANES rows per pass with one multiply-accumulate per lane per cycle.
// It runs MTX_SIZE / LANES passes of MTX_SIZE cycles each.
// out_valid_o rises PASSES * MTX_SIZE + 1 clock edges after the accept edge.
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   reset_ni     asynchronous active-low reset
//   in_valid_i   operands valid
//   in_ready_o   block can accept operands (IDLE only)
//   mode_i       0: C*x, 1: C^T*x; sampled on accept
//   mtx_row_i    first row of C, canonical elements
//   vec_i        vector x, canonical elements
//   result_o     registered result y, canonical elements
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   op_count_o   completed output handshakes (only with CIRC_MTX_PERF_CNT_EN)
//
// Optional feature: define CIRC_MTX_PERF_CNT_EN to add the op_count_o counter.
module circ_mtx_vec_mul_seq #(
    parameter int unsigned WORD_WIDTH = 31,
    parameter int unsigned MTX_SIZE   = 16,
    parameter int unsigned LANES      = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_ni,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic                                  mode_i,
    input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]   mtx_row_i,
    input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]   vec_i,
    output logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]   result_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i
`ifdef CIRC_MTX_PERF_CNT_EN
    ,
    output logic [31:0]                           op_count_o
`endif
);

    localparam int unsigned PASSES = MTX_SIZE / LANES;
    localparam int unsigned IW     = $clog2(MTX_SIZE);
    localparam int unsigned PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

    if (WORD_WIDTH != 31) begin : g_bad_width
        $error("circ_mtx_vec_mul_seq: WORD_WIDTH must be 31 for M31 reduction");
    end
    if (MTX_SIZE < 2 || (MTX_SIZE & (MTX_SIZE - 1)) != 0) begin : g_bad_size
        $error("circ_mtx_vec_mul_seq: MTX_SIZE must be a power of two >= 2");
    end
    if (LANES == 0 || (LANES & (LANES - 1)) != 0 || LANES > MTX_SIZE) begin : g_bad_lanes
        $error("circ_mtx_vec_mul_seq: LANES must be a power of two dividing MTX_SIZE");
    end

    // Fold a value below 2^62 into [0, p) using 2^31 == 1 (mod p).
    function automatic logic [30:0] m31_fold(input logic [61:0] v);
        logic [31:0] s;
        logic [30:0] t;
        s = {1'b0, v[30:0]} + {1'b0, v[61:31]};
        t = s[30:0] + {30'd0, s[31]};
        return (t == 31'h7FFF_FFFF) ? 31'd0 : t;
    endfunction

    typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

    state_e                                state_q, state_d;
    logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]   row_q, row_d;
    logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]   vec_q, vec_d;
    logic [MTX_SIZE-1:0][WORD_WIDTH-1:0]   result_q, result_d;
    logic                                  mode_q, mode_d;
    logic [PW-1:0]                         pass_q, pass_d;
    logic [IW-1:0]                         col_q, col_d;
    logic [LANES-1:0][WORD_WIDTH-1:0]      acc_q, acc_d;
    logic                                  out_valid_q, out_valid_d;

    logic [LANES-1:0][WORD_WIDTH-1:0]      mac;
    logic [LANES-1:0][IW-1:0]              row_idx;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IW-1:0]           coef_idx;
        logic [WORD_WIDTH-1:0]   coef;
        logic [2*WORD_WIDTH-1:0] prod;

        assign row_idx[l] = IW'(32'(pass_q) * LANES + l);
        // The subtraction wraps modulo MTX_SIZE because MTX_SIZE is a power of two.
        assign coef_idx   = mode_q ? (row_idx[l] - col_q) : (col_q - row_idx[l]);
        assign coef       = row_q[coef_idx];
        assign prod       = {{WORD_WIDTH{1'b0}}, coef} * {{WORD_WIDTH{1'b0}}, vec_q[col_q]};
        assign mac[l]     = m31_fold({30'd0, ({1'b0, acc_q[l]} + {1'b0, m31_fold(prod)})});
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        vec_d       = vec_q;
        result_d    = result_q;
        mode_d      = mode_q;
        pass_d      = pass_q;
        col_d       = col_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    row_d   = mtx_row_i;
                    vec_d   = vec_i;
                    mode_d  = mode_i;
                    pass_d  = '0;
                    col_d   = '0;
                    acc_d   = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                acc_d = mac;
                if (col_q == IW'(MTX_SIZE - 1)) begin
                    for (int l = 0; l < LANES; l++) begin
                        result_d[row_idx[l]] = mac[l];
                    end
                    acc_d = '0;
                    col_d = '0;
                    if (pass_q == PW'(PASSES - 1)) begin
                        state_d = StDone;
                    end else begin
                        pass_d = pass_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StDone: begin
                // out_valid is raised one edge after entering DONE and drops after the handshake.
                out_valid_d = ~(out_valid_q & out_ready_i);
                if (out_valid_q && out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            row_q       <= '0;
            vec_q       <= '0;
            result_q    <= '0;
            mode_q      <= 1'b0;
            pass_q      <= '0;
            col_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            vec_q       <= vec_d;
            result_q    <= result_d;
            mode_q      <= mode_d;
            pass_q      <= pass_d;
            col_q       <= col_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;

`ifdef CIRC_MTX_PERF_CNT_EN
    logic [31:0] op_count_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            op_count_q <= '0;
        end else if (out_valid_q && out_ready_i) begin
            op_count_q <= op_count_q + 32'd1;
        end
    end

    assign op_count_o = op_count_q;
`endif

endmodule

// File: tb/tb_circ_mtx_vec_mul_seq.sv
// Directed self-checking bench for circ_mtx_vec_mul_seq with default parameters.
module tb_circ_mtx_vec_mul_seq;

    localparam int N = 16;
    localparam int W = 31;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               mode = 1'b0;
    logic [N-1:0][W-1:0] mtx_row = '0;
    logic [N-1:0][W-1:0] vec = '0;
    logic [N-1:0][W-1:0] result;
    logic [N-1:0][W-1:0] exp_res;
    logic               out_valid;
    logic               out_ready = 1'b1;
`ifdef CIRC_MTX_PERF_CNT_EN
    logic [31:0]        op_count;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int lat;

    always #5 clk = ~clk;

    circ_mtx_vec_mul_seq dut (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mode_i      (mode),
        .mtx_row_i   (mtx_row),
        .vec_i       (vec),
        .result_o    (result),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
`ifdef CIRC_MTX_PERF_CNT_EN
        ,
        .op_count_o  (op_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic check_result(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s[%0d]", tag, i), 32'(result[i]), 32'(exp_res[i]));
        end
    endtask

    // Waits for IDLE, presents one operation, then scrambles the inputs after the accept edge.
    task automatic start_op(input logic m);
        int guard = 0;
        while (!in_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("start_in_ready", 32'(in_ready), 32'd1);
        mode     = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mode     = ~m;
        for (int i = 0; i < N; i++) begin
            mtx_row[i] = 31'h0123_4567;
            vec[i]     = 31'h0765_4321;
        end
    endtask

    // Counts edges from the accept edge until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input logic m, input string tag);
        start_op(m);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'd65);
        check_result(tag);
    endtask

    task automatic load_shift_inputs();
        for (int i = 0; i < N; i++) begin
            mtx_row[i] = (i == 1) ? 31'd1 : 31'd0;
            vec[i]     = 31'(i);
        end
    endtask

    task automatic load_wrap_inputs(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) begin
            mtx_row[i] = 31'h7FFF_FFFE;
            vec[i]     = v;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result_zero", 32'(|result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity
        for (int i = 0; i < N; i++) begin
            mtx_row[i] = (i == 0) ? 31'd1 : 31'd0;
            vec[i]     = 31'(i);
            exp_res[i] = 31'(i);
        end
        run_op(1'b0, "ident");
        @(posedge clk); #1;
        check("ident_valid_one_cycle", 32'(out_valid), 32'd0);
        check("ident_back_to_idle", 32'(in_ready), 32'd1);

        // Shift, mode 0 and mode 1
        load_shift_inputs();
        for (int i = 0; i < N; i++) exp_res[i] = 31'((i + 1) % N);
        run_op(1'b0, "shift_m0");
        load_shift_inputs();
        for (int i = 0; i < N; i++) exp_res[i] = 31'((i + N - 1) % N);
        run_op(1'b1, "shift_m1");

        // Modular wrap
        load_wrap_inputs(31'd1);
        for (int i = 0; i < N; i++) exp_res[i] = 31'h7FFF_FFEF;
        run_op(1'b0, "wrap_neg16");
        load_wrap_inputs(31'h7FFF_FFFE);
        for (int i = 0; i < N; i++) exp_res[i] = 31'd16;
        run_op(1'b1, "wrap_pos16");

        // Backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        load_shift_inputs();
        for (int i = 0; i < N; i++) exp_res[i] = 31'((i + N - 1) % N);
        run_op(1'b1, "bp");
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            mode     = 1'b0;
            load_wrap_inputs(31'd1);
            @(posedge clk); #1;
            check($sformatf("bp_valid_%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'd0);
            check($sformatf("bp_stable_%0d", c), 32'(result == exp_res), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        load_wrap_inputs(31'd1);
        for (int i = 0; i < N; i++) exp_res[i] = 31'h7FFF_FFEF;
        run_op(1'b0, "bp_next");

        // Reset mid-operation
        @(posedge clk); #1;
        load_shift_inputs();
        start_op(1'b0);
        repeat (29) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_result_zero", 32'(|result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_no_output", 32'(out_valid), 32'd0);
        load_shift_inputs();
        for (int i = 0; i < N; i++) exp_res[i] = 31'((i + 1) % N);
        run_op(1'b0, "midrst_fresh");

`ifdef CIRC_MTX_PERF_CNT_EN
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("perf_rst0", op_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            load_wrap_inputs(31'h7FFF_FFFE);
            for (int i = 0; i < N; i++) exp_res[i] = 31'd16;
            run_op(1'b0, $sformatf("perf_op%0d", k));
        end
        @(posedge clk); #1;
        check("perf_count3", op_count, 32'd3);
        rst_n = 1'b0;
        #1;
        check("perf_rst1", op_count, 32'd0);
        rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
